// File: rtl/opacc_tile.sv
// opacc_tile: ROWS x COLS outer-product accumulator tile driven by a command FSM.
// Commands: LOAD (row-wise C fill), ZERO, multi-beat ACC (add/sub a[i]*b[j]),
// and STORE (row-wise drain with backpressure, non-destructive).
// Optional build macro OPACC_SAT_EN: signed saturating ACC plus a sticky sat_flag
// output; without it ACC wraps modulo 2^XLEN and sat_flag does not exist.
module opacc_tile #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int XLEN = 64,
    parameter int LENW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic                 cmd_sub,
    input  logic [LENW-1:0]      cmd_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*XLEN-1:0] in_a,
    input  logic [COLS*XLEN-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLS*XLEN-1:0] out_row,
    output logic                 out_last,
    output logic                 busy
`ifdef OPACC_SAT_EN
    ,
    output logic                 sat_flag
`endif
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ACC, ST_STORE} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'd0, OP_ZERO = 2'd1, OP_ACC = 2'd2, OP_STORE = 2'd3} op_t;

    state_t          state, state_next;
    logic [RW-1:0]   row_cnt;
    logic [LENW-1:0] beat_cnt;
    logic            sub_q;
    logic [XLEN-1:0] acc     [ROWS][COLS];
    logic [XLEN-1:0] acc_upd [ROWS][COLS];

`ifdef OPACC_SAT_EN
    localparam logic signed [2*XLEN+1:0] SAT_MAX = {{(XLEN+3){1'b0}}, {(XLEN-1){1'b1}}};
    localparam logic signed [2*XLEN+1:0] SAT_MIN = {{(XLEN+3){1'b1}}, {(XLEN-1){1'b0}}};
    logic [ROWS*COLS-1:0] sat_el;
`endif

    // Per-element next value for an ACC beat: acc +/- a[i]*b[j]
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            logic [XLEN-1:0] a_el, b_el;
            assign a_el = in_a[gi*XLEN +: XLEN];
            assign b_el = in_b[gj*XLEN +: XLEN];
`ifdef OPACC_SAT_EN
            logic signed [2*XLEN-1:0] prod;
            logic signed [2*XLEN+1:0] acc_x, prod_x, sum;
            logic                     sat_hi, sat_lo;
            // Two guard bits keep the full-width sum exact before clamping.
            assign prod   = $signed({{XLEN{a_el[XLEN-1]}}, a_el}) * $signed({{XLEN{b_el[XLEN-1]}}, b_el});
            assign acc_x  = {{(XLEN+2){acc[gi][gj][XLEN-1]}}, acc[gi][gj]};
            assign prod_x = {{2{prod[2*XLEN-1]}}, prod};
            assign sum    = sub_q ? (acc_x - prod_x) : (acc_x + prod_x);
            assign sat_hi = (sum > SAT_MAX);
            assign sat_lo = (sum < SAT_MIN);
            assign acc_upd[gi][gj] = sat_hi ? {1'b0, {(XLEN-1){1'b1}}} :
                                     sat_lo ? {1'b1, {(XLEN-1){1'b0}}} : sum[XLEN-1:0];
            assign sat_el[gi*COLS+gj] = sat_hi | sat_lo;
`else
            logic [XLEN-1:0] prod_lo;
            assign prod_lo = a_el * b_el;
            assign acc_upd[gi][gj] = sub_q ? (acc[gi][gj] - prod_lo) : (acc[gi][gj] + prod_lo);
`endif
        end
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        state_next = state;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (op_t'(cmd_op))
                        OP_LOAD:  state_next = ST_LOAD;
                        OP_ACC:   if (cmd_len != '0) state_next = ST_ACC;
                        OP_STORE: state_next = ST_STORE;
                        default:  state_next = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && row_cnt == ROW_LAST) state_next = ST_IDLE;
            end
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid && beat_cnt == LENW'(1)) state_next = ST_IDLE;
            end
            ST_STORE: begin
                out_valid = 1'b1;
                if (out_ready && row_cnt == ROW_LAST) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Drain row mux straight from the accumulator registers
    always_comb begin
        out_row  = '0;
        for (int j = 0; j < COLS; j++) out_row[j*XLEN +: XLEN] = acc[row_cnt][j];
        out_last = (state == ST_STORE) && (row_cnt == ROW_LAST);
    end

    // Accumulator array, counters and latched ACC direction
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the accumulators are a flop array, not a RAM, so reset clears them like any register.
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) acc[i][j] <= '0;
            row_cnt  <= '0;
            beat_cnt <= '0;
            sub_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (op_t'(cmd_op))
                            OP_LOAD:  row_cnt <= '0;
                            OP_ZERO: begin
                                for (int i = 0; i < ROWS; i++)
                                    for (int j = 0; j < COLS; j++) acc[i][j] <= '0;
                            end
                            OP_ACC: begin
                                beat_cnt <= cmd_len;
                                sub_q    <= cmd_sub;
                            end
                            default:  row_cnt <= '0;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        for (int j = 0; j < COLS; j++) acc[row_cnt][j] <= in_b[j*XLEN +: XLEN];
                        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        for (int i = 0; i < ROWS; i++)
                            for (int j = 0; j < COLS; j++) acc[i][j] <= acc_upd[i][j];
                        beat_cnt <= beat_cnt - 1'b1;
                    end
                end
                ST_STORE: begin
                    if (out_ready) row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                end
                default: row_cnt <= '0;
            endcase
        end
    end

`ifdef OPACC_SAT_EN
    // Sticky saturation flag: set by a saturating ACC beat, cleared by ZERO
    always_ff @(posedge clk) begin
        if (reset)
            sat_flag <= 1'b0;
        else if (state == ST_IDLE && cmd_valid && op_t'(cmd_op) == OP_ZERO)
            sat_flag <= 1'b0;
        else if (state == ST_ACC && in_valid && (|sat_el))
            sat_flag <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_opacc_tile.sv
// Self-checking bench for opacc_tile (ROWS=COLS=4, XLEN=16). A behavioural
// accumulator model predicts contents; STORE pushes expected rows to a queue
// that is popped on each drain handshake.
module tb_opacc_tile;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int XLEN = 16;
    localparam int LENW = 8;
    localparam int AW   = ROWS * XLEN;
    localparam int BW   = COLS * XLEN;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_ZERO  = 2'd1;
    localparam logic [1:0] OP_ACC   = 2'd2;
    localparam logic [1:0] OP_STORE = 2'd3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = '0;
    logic            cmd_sub = 1'b0;
    logic [LENW-1:0] cmd_len = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [AW-1:0]   in_a = '0;
    logic [BW-1:0]   in_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BW-1:0]   out_row;
    logic            out_last;
    logic            busy;
`ifdef OPACC_SAT_EN
    logic            sat_flag;
    logic            m_sat = 1'b0;
`endif

    opacc_tile #(.ROWS(ROWS), .COLS(COLS), .XLEN(XLEN), .LENW(LENW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_sub   (cmd_sub),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy)
`ifdef OPACC_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] m_acc [ROWS][COLS];

    typedef struct packed {
        logic [BW-1:0] row;
        logic          last;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [BW-1:0] vec4(input logic [XLEN-1:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [XLEN-1:0] model_op(input logic [XLEN-1:0] acc_v, a_v, b_v, input logic sub);
`ifdef OPACC_SAT_EN
        longint p, s, hi, lo;
        hi = (longint'(1) << (XLEN-1)) - 1;
        lo = -(longint'(1) << (XLEN-1));
        p  = longint'($signed(a_v)) * longint'($signed(b_v));
        s  = sub ? longint'($signed(acc_v)) - p : longint'($signed(acc_v)) + p;
        if (s > hi) begin m_sat = 1'b1; s = hi; end
        if (s < lo) begin m_sat = 1'b1; s = lo; end
        return XLEN'(s);
`else
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, a_v} * {{XLEN{1'b0}}, b_v};
        return sub ? acc_v - p[XLEN-1:0] : acc_v + p[XLEN-1:0];
`endif
    endfunction

    task automatic model_zero();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) m_acc[i][j] = '0;
`ifdef OPACC_SAT_EN
        m_sat = 1'b0;
`endif
    endtask

    // Offer a command at a falling edge and hold it until the next rising edge accepts it.
    task automatic do_cmd(input logic [1:0] op, input logic sub, input logic [LENW-1:0] len);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_sub = sub; cmd_len = len;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_accept op=%0d: cmd_ready=%b required 1", op, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        if (op == OP_ZERO) model_zero();
    endtask

    // One LOAD or ACC operand beat; model updated as the beat is offered.
    task automatic do_beat(input logic [AW-1:0] a, input logic [BW-1:0] b,
                           input bit is_acc, input logic sub, input int row);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_accept: in_ready=%b required 1", in_ready);
        end
        if (is_acc) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    m_acc[i][j] = model_op(m_acc[i][j], a[i*XLEN +: XLEN], b[j*XLEN +: XLEN], sub);
        end else begin
            for (int j = 0; j < COLS; j++) m_acc[row][j] = b[j*XLEN +: XLEN];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [XLEN-1:0] base, input logic [XLEN-1:0] step);
        do_cmd(OP_LOAD, 1'b0, '0);
        for (int r = 0; r < ROWS; r++) begin
            logic [XLEN-1:0] v;
            v = base + XLEN'(r) * step;
            do_beat('0, vec4(v, v + 16'd1, v + 16'd2, v + 16'd3), 1'b0, 1'b0, r);
        end
    endtask

    // Drain all rows; pat[k%4] drives out_ready on cycle k. poke_cmd holds a ZERO
    // command on cmd_valid throughout the drain, which must never be accepted.
    task automatic do_store(input logic [3:0] pat, input bit poke_cmd);
        logic [BW-1:0] held = '0;
        bit stalled = 1'b0;
        int k = 0;
        int cyc = 0;
        for (int r = 0; r < ROWS; r++)
            exp_q.push_back('{row: vec4(m_acc[r][0], m_acc[r][1], m_acc[r][2], m_acc[r][3]),
                              last: (r == ROWS-1)});
        do_cmd(OP_STORE, 1'b0, '0);
        if (poke_cmd) begin cmd_valid = 1'b1; cmd_op = OP_ZERO; end
        while (exp_q.size() > 0 && k < 100) begin
            out_ready = pat[k % 4];
            k++;
            if (poke_cmd) begin
                total++;
                if (cmd_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL store_cmd_blocked: cmd_ready=%b required 0", cmd_ready);
                end
            end
            if (stalled) begin
                total++;
                if (out_row !== held) begin
                    bad++;
                    $display("FAIL stall_hold: out_row=%h required %h", out_row, held);
                end
            end
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL store_valid: out_valid=%b required 1", out_valid);
            end else begin
                cyc++;
                if (out_row !== exp_q[0].row || out_last !== exp_q[0].last) begin
                    bad++;
                    $display("FAIL store_row: out_row=%h last=%b required %h last=%b",
                             out_row, out_last, exp_q[0].row, exp_q[0].last);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_row;
                end
            end
            if (exp_q.size() == 0) cmd_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b0;
        cmd_valid = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL store_timeout: rows_left=%0d required 0", exp_q.size());
        end
        exp_q.delete();
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL store_end: busy=%b cmd_ready=%b out_valid=%b required 0 1 0",
                     busy, cmd_ready, out_valid);
        end
        if (pat == 4'hF) begin
            total++;
            if (cyc != ROWS) begin
                bad++;
                $display("FAIL store_cycles: cycles=%0d required %0d", cyc, ROWS);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 ||
            out_valid !== 1'b0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: cmd_ready=%b busy=%b in_ready=%b out_valid=%b out_last=%b required 1 0 0 0 0",
                     cmd_ready, busy, in_ready, out_valid, out_last);
        end
        reset = 1'b0;
        model_zero();
        do_store(4'hF, 1'b0);
    endtask

    task automatic test_load_store();
        do_cmd(OP_ZERO, 1'b0, '0);
        do_load(16'd1, 16'd4);
        do_store(4'hF, 1'b0);
    endtask

    task automatic test_acc();
        do_cmd(OP_ZERO, 1'b0, '0);
        do_cmd(OP_ACC, 1'b0, 8'd2);
        do_beat(vec4(16'd1, 16'd2, 16'd3, 16'd4), vec4(16'd1, 16'd1, 16'd1, 16'd1), 1'b1, 1'b0, 0);
        // operand stall: nothing moves while in_valid is low
        repeat (2) begin
            total++;
            if (busy !== 1'b1 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL acc_stall: busy=%b in_ready=%b required 1 1", busy, in_ready);
            end
            @(negedge clk);
        end
        do_beat(vec4(16'd2, 16'd2, 16'd2, 16'd2), vec4(16'd2, 16'd2, 16'd2, 16'd2), 1'b1, 1'b0, 0);
        do_store(4'hF, 1'b0);
    endtask

    task automatic test_acc_sub_len0();
        do_cmd(OP_ACC, 1'b1, 8'd1);
        do_beat(vec4(16'd1, 16'd1, 16'd1, 16'd1), vec4(16'd1, 16'd1, 16'd1, 16'd1), 1'b1, 1'b1, 0);
        do_store(4'hF, 1'b0);
        do_cmd(OP_ACC, 1'b0, 8'd0);
        repeat (3) begin
            total++;
            if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
                bad++;
                $display("FAIL acc_len0: busy=%b cmd_ready=%b required 0 1", busy, cmd_ready);
            end
            @(negedge clk);
        end
        do_store(4'hF, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_store(4'b1001, 1'b1);
        do_store(4'hF, 1'b0);
    endtask

    task automatic test_wrap();
        logic [XLEN-1:0] top;
`ifdef OPACC_SAT_EN
        top = 16'h7FFF;
`else
        top = 16'hFFFF;
`endif
        do_cmd(OP_LOAD, 1'b0, '0);
        do_beat('0, vec4(top, top, top, top), 1'b0, 1'b0, 0);
        do_beat('0, vec4(16'd5, 16'd6, 16'd7, 16'd8), 1'b0, 1'b0, 1);
        do_beat('0, vec4(16'd0, 16'd0, 16'd0, 16'd0), 1'b0, 1'b0, 2);
        do_beat('0, vec4(16'h8000, 16'h1234, 16'h00FF, 16'h7FFE), 1'b0, 1'b0, 3);
        do_cmd(OP_ACC, 1'b0, 8'd1);
        do_beat(vec4(16'd1, 16'd1, 16'd1, 16'd1), vec4(16'd1, 16'd1, 16'd1, 16'd1), 1'b1, 1'b0, 0);
        do_store(4'hF, 1'b0);
`ifdef OPACC_SAT_EN
        total++;
        if (sat_flag !== m_sat) begin
            bad++;
            $display("FAIL sat_flag_set: sat_flag=%b required %b", sat_flag, m_sat);
        end
        do_cmd(OP_ZERO, 1'b0, '0);
        total++;
        if (sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL sat_flag_clear: sat_flag=%b required 0", sat_flag);
        end
`endif
    endtask

    task automatic test_reset_mid_acc();
        do_load(16'd9, 16'd3);
        do_cmd(OP_ACC, 1'b0, 8'd4);
        do_beat(vec4(16'd1, 16'd2, 16'd3, 16'd4), vec4(16'd5, 16'd6, 16'd7, 16'd8), 1'b1, 1'b0, 0);
        in_valid = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_acc: busy=%b cmd_ready=%b out_valid=%b in_ready=%b required 0 1 0 0",
                     busy, cmd_ready, out_valid, in_ready);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        model_zero();
        do_store(4'hF, 1'b0);
    endtask

    initial begin
        model_zero();
        @(negedge clk);
        test_reset();
        test_load_store();
        test_acc();
        test_acc_sub_len0();
        test_back_to_back();
        test_wrap();
        test_reset_mid_acc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/opacc_tile.md
Name: opacc_tile

Overview:
Parametrised outer-product accumulator tile for the MPU: ROWS x COLS array of XLEN accumulators updated by rank-1 products a[i]*b[j]. A command FSM replaces ad hoc valid strobes: LOAD row-wise, ZERO, multi-beat ACC (add or subtract), and STORE row-wise drain with backpressure. Sits between the MPU operand sequencer (A/B/C row streams) and the vector result writeback.

Parameters:
ROWS, 4, accumulator rows (length of in_a); >=2
COLS, 4, accumulator columns (length of in_b, out_row); >=1
XLEN, 64, element and accumulator width
LENW, 8, width of cmd_len

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_op  input  2  0 LOAD, 1 ZERO, 2 ACC, 3 STORE
cmd_sub  input  1  ACC only: subtract products instead of add
cmd_len  input  LENW  ACC only: number of operand beats
in_valid  input  1  operand/row beat offered
in_ready  output  1  operand beat accepted when in_valid && in_ready
in_a  input  ROWS*XLEN  A column vector (ACC)
in_b  input  COLS*XLEN  B row vector (ACC) or C row data (LOAD)
out_valid  output  1  drain row valid
out_ready  input  1  drain row consumed
out_row  output  COLS*XLEN  accumulator row being drained
out_last  output  1  out_valid on final row (ROWS-1)
busy  output  1  state != IDLE

Behaviour:
- Clock clk; reset synchronous active-high. Reset (any time, including mid-command): state IDLE, all accumulators 0, counters 0, out_valid 0, in_ready 0, cmd_ready 1, busy 0.
- States: IDLE, LOAD, ACC, STORE. ZERO completes inside IDLE.
- IDLE: cmd_ready=1, in_ready=0, out_valid=0. On cmd accept: LOAD -> LOAD, row_cnt=0; ZERO -> all accumulators 0 next edge, remain IDLE; ACC with cmd_len=0 -> no-op, remain IDLE; ACC with cmd_len>0 -> ACC, beat_cnt=cmd_len, latch cmd_sub; STORE -> STORE, row_cnt=0.
- cmd_ready=0 in every non-IDLE state; commands there are neither accepted nor queued.
- LOAD: in_ready=1. Each accepted beat writes in_b into row row_cnt (row 0 first), row_cnt++. After beat ROWS-1 -> IDLE (cmd_ready 1 next cycle). in_a ignored.
- ACC: in_ready=1. Each accepted beat: acc[i][j] <= acc[i][j] +/- low XLEN bits of (in_a[i]*in_b[j]), modulo 2^XLEN (signedness irrelevant without the optional feature). beat_cnt-- ; at the beat where beat_cnt==1 -> IDLE. Update is visible the next cycle; no multi-cycle latency.
- in_valid stalls (in_valid=0) hold state and counters; no timeout.
- STORE: out_valid=1, out_row=acc[row_cnt] (combinational from registers), out_last=(row_cnt==ROWS-1). On out_valid && out_ready: row_cnt++; after last row -> IDLE. out_row held stable while out_ready=0. Drain is non-destructive.
- busy=1 in LOAD, ACC, STORE.
- Throughput: one beat per cycle in LOAD/ACC/STORE. Command turnaround: one IDLE cycle between commands.

Optional Feature:
OPACC_SAT_EN: when defined, ACC treats operands and accumulators as signed two's complement; the product is computed at full 2*XLEN width and the sum/difference is saturated to [-2^(XLEN-1), 2^(XLEN-1)-1]. An extra output sat_flag (1 bit) is set sticky on any saturation event, cleared by reset or ZERO. When undefined: wrap-around arithmetic as above and no sat_flag port.

Test Plan:
ROWS=COLS=4, XLEN=16: ZERO; LOAD rows {1,2,3,4}+4r; STORE with out_ready=1 -> 4 rows in order in 4 cycles, out_last only on row 3, values unchanged.
ZERO; ACC len=2, beats a={1,2,3,4}, b={1,1,1,1}, then a=b={2,2,2,2}; STORE -> acc[i][j]=(i+1)+4.
After previous, ACC sub len=1 with a=b={1,1,1,1}; STORE -> every element decremented by 1; ACC len=0 -> cmd_ready stays 1, busy never asserts, contents unchanged.
STORE with out_ready toggling 1,0,0,1: out_row stable during stalls, row_cnt advances only on handshakes; cmd_valid during STORE not accepted.
Wrap: acc=0xFFFF, ACC a=1,b=1 -> 0x0000 (macro undefined); with OPACC_SAT_EN, acc=0x7FFF plus 1*1 -> 0x7FFF and sat_flag=1.
Assert reset during ACC beat 2 of 4 -> next cycle IDLE, all acc 0, out_valid 0, cmd_ready 1.
